// File: rtl/gf180mcu_bist_pkg.sv
// Shared definitions for the AND3 cell-bank BIST.
//   bist_state_t : controller states
//   NUM_VEC      : number of exhaustive input vectors for a 3-input cell
//   and3_exp()   : golden response of an AND3 cell for a given vector
package gf180mcu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    localparam int NUM_VEC = 8;

    // Vector bit 0 drives A1, bit 1 A2, bit 2 A3; Z is their AND.
    function automatic logic and3_exp(input logic [2:0] vec);
        return vec[0] & vec[1] & vec[2];
    endfunction

endpackage

// File: rtl/gf180mcu_bist_settle_cnt.sv
// Loadable down-counter that times the settle window of the BIST.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement request; saturates at zero
//   zero_o     : counter is zero
module gf180mcu_bist_settle_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, saturating decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/gf180mcu_and3_bist.sv
// Built-in self-test driver/checker for a bank of AND3 cells.
// Applies the 8 input vectors to all lanes, waits SETTLE_CYC cycles,
// samples Z and reports pass/fail, the first failing vector and the
// OR of failing lanes.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   START      : start a run (honoured only when idle or done)
//   A1/A2/A3   : per-lane cell inputs (vector bits 0/1/2)
//   Z          : per-lane cell outputs
//   BUSY/DONE  : run in progress / run finished (held)
//   PASS       : no mismatch seen (valid with DONE)
//   FAIL_VEC   : first mismatching vector
//   FAIL_LANES : OR of mismatching lanes
module gf180mcu_and3_bist #(
    parameter int N_LANES      = 4,
    parameter int SETTLE_CYC   = 2,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic [N_LANES-1:0] A1,
    output logic [N_LANES-1:0] A2,
    output logic [N_LANES-1:0] A3,
    input  logic [N_LANES-1:0] Z,
    output logic               BUSY,
    output logic               DONE,
    output logic               PASS,
    output logic [2:0]         FAIL_VEC,
    output logic [N_LANES-1:0] FAIL_LANES
);
    import gf180mcu_bist_pkg::*;

    localparam int               CNT_W     = $clog2(SETTLE_CYC + 1);
    // The DRIVE->SETTLE edge loads the counter, so SETTLE lasts load+1 cycles.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       LAST_VEC  = 3'(NUM_VEC - 1);

    bist_state_t        state_q;
    logic [2:0]         vec_q;
    logic [N_LANES-1:0] a1_q, a2_q, a3_q;
    logic               busy_q, done_q, pass_q;
    logic [2:0]         fail_vec_q;
    logic [N_LANES-1:0] fail_lanes_q;
    logic [N_LANES-1:0] mism_s;
    logic               cnt_load_s, cnt_dec_s, cnt_zero_s;

    assign cnt_load_s = (state_q == ST_DRIVE);
    assign cnt_dec_s  = (state_q == ST_SETTLE);

    gf180mcu_bist_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load_s),
        .load_val_i (SETTLE_LD),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Per-lane mismatch; Z is only looked at in CHECK.
    always_comb begin
        mism_s = {N_LANES{1'b0}};
        if (state_q == ST_CHECK) begin
            mism_s = Z ^ {N_LANES{and3_exp(vec_q)}};
        end else begin
            mism_s = {N_LANES{1'b0}};
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            vec_q        <= 3'd0;
            a1_q         <= {N_LANES{1'b0}};
            a2_q         <= {N_LANES{1'b0}};
            a3_q         <= {N_LANES{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= 3'd0;
            fail_lanes_q <= {N_LANES{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= 3'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_vec_q   <= 3'd0;
                        fail_lanes_q <= {N_LANES{1'b0}};
                    end
                end
                ST_DRIVE: begin
                    a1_q    <= {N_LANES{vec_q[0]}};
                    a2_q    <= {N_LANES{vec_q[1]}};
                    a3_q    <= {N_LANES{vec_q[2]}};
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_zero_s) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    fail_lanes_q <= fail_lanes_q | mism_s;
                    // An empty accumulated mask means no earlier vector failed.
                    if ((mism_s != {N_LANES{1'b0}}) && (fail_lanes_q == {N_LANES{1'b0}})) begin
                        fail_vec_q <= vec_q;
                    end
                    if (((mism_s != {N_LANES{1'b0}}) && (STOP_ON_FAIL != 0)) ||
                        (vec_q == LAST_VEC)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ((fail_lanes_q | mism_s) == {N_LANES{1'b0}});
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        state_q <= ST_DRIVE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign A1         = a1_q;
    assign A2         = a2_q;
    assign A3         = a3_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign FAIL_VEC   = fail_vec_q;
    assign FAIL_LANES = fail_lanes_q;

endmodule
